prn_stim_timer: RTL and testbench
=================================

PRN_STIM_TIMER -- requirements
Module: prn_stim_timer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd5_000_000, is the STIM cycles allowed before a timeout result.
REQ-002 Parameter HOLDOFF_CYCLES, default 16'd1000, is the minimum cycles spent in HOLDOFF.
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 prn  in  3  pseudo-random code from the upstream LFSR, asynchronous to clk.
REQ-006 en  in  1  enable; 0 forces IDLE.
REQ-007 resp  in  8  response buttons, already debounced and synchronous to clk, active-high.
REQ-008 stim  out  8  one-hot stimulus, bit index = accepted prn code, registered.
REQ-009 busy  out  1  high in STIM, REPORT and HOLDOFF.
REQ-010 res_valid  out  1  one-cycle result strobe.
REQ-011 res_code  out  2  result code: 00 hit, 01 wrong, 10 timeout, 11 unused.
REQ-012 res_cycles  out  24  reaction time in clk cycles.

Function
REQ-013 Each prn bit SHALL pass through a two-flop synchronizer; the result is prn_s.
REQ-014 A code SHALL be accepted only when prn_s equals its own value from the previous cycle (stable for 2 cycles) and differs from last_prn.
REQ-015 States SHALL be IDLE, ARMED, STIM, REPORT and HOLDOFF.
REQ-016 IDLE SHALL go to ARMED when en=1; any state SHALL go to IDLE at the next edge when en=0, with no res_valid.
REQ-017 On acceptance in ARMED: last_prn <= prn_s, stim <= one-hot(prn_s), counter <= 0, next state STIM.
REQ-018 Latency: the first stim cycle SHALL occur at the 4th clk rising edge after a prn change settles at the input.
REQ-019 In STIM the counter SHALL increment each cycle, saturating at 24'hFFFFFF.
REQ-020 In STIM, resp == stim SHALL give a hit (00).
REQ-021 In STIM, resp nonzero and not equal to stim SHALL give wrong (01); this includes the correct bit pressed together with others.
REQ-022 On hit or wrong, res_cycles SHALL equal the counter value in the cycle resp was sampled.
REQ-023 STIM SHALL go to REPORT on a result; stim clears on entry to REPORT.
REQ-024 REPORT SHALL last exactly one cycle: res_valid=1 with res_code and res_cycles valid.
REQ-025 res_code and res_cycles SHALL hold until the next REPORT.
REQ-026 HOLDOFF SHALL go to ARMED once HOLDOFF_CYCLES have elapsed and resp has been all-zero for 1 cycle.
REQ-027 prn changes during STIM, REPORT or HOLDOFF SHALL be ignored, and last_prn SHALL stay unchanged; a pending difference is accepted immediately on return to ARMED.
REQ-028 prn code 0 SHALL be legal and drive stim[0].

Reset
REQ-029 While rst is asserted: state IDLE; stim=0, busy=0, res_valid=0, res_code=00, res_cycles=0; last_prn=3'b000; synchronizers and counters cleared.
REQ-030 Reset asserted mid-STIM SHALL drop stim asynchronously with no res_valid.

Configuration
REQ-031 With PRN_STIM_TIMEOUT_EN defined, STIM SHALL go to REPORT with code 10 and res_cycles=TIMEOUT_CYCLES when the counter reaches TIMEOUT_CYCLES with no resp.
REQ-032 With PRN_STIM_TIMEOUT_EN undefined, no timeout logic SHALL exist; STIM waits indefinitely and the counter saturates.

Structure
REQ-033 A shared package prn_stim_pkg SHALL hold the state enum, the res_code constants (RES_HIT, RES_WRONG, RES_TIMEOUT) and the width constants (CODE_W=3, STIM_W=8, CNT_W=24).
REQ-034 The synchronizer SHALL be sub-module sync2 (two flops, 1-bit, async reset), instantiated three times.

Verification
REQ-035 Reset, en=1, prn 000->101, resp=8'h20 on the 10th STIM cycle -> stim=8'h20 at edge 4 after the change; res_valid pulse; res_code=00; res_cycles=9.
REQ-036 prn=011 accepted, resp=8'h0C -> res_code=01 (wrong), stim cleared in REPORT.
REQ-037 PRN_STIM_TIMEOUT_EN with TIMEOUT_CYCLES=100, no resp -> res_code=10 and res_cycles=100 after 100 STIM cycles; undefined -> no res_valid after 200 cycles.
REQ-038 prn changes 001->110 during STIM -> ignored; stim stays 8'h02; 110 accepted on the first ARMED cycle after HOLDOFF.
REQ-039 rst pulsed mid-STIM -> all outputs 0 with no res_valid; en dropped mid-HOLDOFF -> IDLE and busy=0 next cycle.
REQ-040 prn glitch held for 1 synchronized cycle only -> not accepted; stim stays 0.

Source files
------------

// File: rtl/prn_stim_pkg.sv
// Shared types and constants for the PRN stimulus / reaction timer.
// PRN_STIM_TIMEOUT_EN enables the STIM timeout result.
package prn_stim_pkg;

   localparam int CODE_W = 3;
   localparam int STIM_W = 8;
   localparam int CNT_W  = 24;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_STIM,
      S_REPORT,
      S_HOLDOFF
   } state_e;

   localparam logic [1:0] RES_HIT     = 2'b00;
   localparam logic [1:0] RES_WRONG   = 2'b01;
   localparam logic [1:0] RES_TIMEOUT = 2'b10;

   function automatic logic [STIM_W-1:0] onehot(input logic [CODE_W-1:0] c);
      logic [STIM_W-1:0] v;
      v    = '0;
      v[c] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/prn_stim_timer_sync2.sv
// Two-flop synchronizer, 1 bit, asynchronous active-high reset.
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic ff1_q, ff1_d;
   logic ff2_q, ff2_d;

   always_comb begin
      ff1_d = d;
      ff2_d = ff1_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ff1_q <= 1'b0;
         ff2_q <= 1'b0;
      end else begin
         ff1_q <= ff1_d;
         ff2_q <= ff2_d;
      end
   end

   assign q = ff2_q;

endmodule

// File: rtl/prn_stim_timer.sv
// Reaction timer: presents a one-hot stimulus from the PRN code and times the response.
// Define PRN_STIM_TIMEOUT_EN to enable the timeout result in STIM.
module prn_stim_timer
   import prn_stim_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000,
   parameter logic [15:0] HOLDOFF_CYCLES = 16'd1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  prn,
   input  logic        en,
   input  logic [7:0]  resp,
   output logic [7:0]  stim,
   output logic        busy,
   output logic        res_valid,
   output logic [1:0]  res_code,
   output logic [23:0] res_cycles
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CODE_W-1:0] prn_s;
   logic [CODE_W-1:0] prn_prev_q, prn_prev_d;
   logic [CODE_W-1:0] last_prn_q, last_prn_d;
   logic [STIM_W-1:0] stim_q, stim_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        res_code_q, res_code_d;
   logic [CNT_W-1:0]  res_cycles_q, res_cycles_d;
   state_e            state_q, state_d;

   logic              accept;
   logic              resp_any;
   logic              hold_done;
   logic [CNT_W-1:0]  cnt_inc;
   logic [CNT_W:0]    elapsed;

   sync2 u_sync0 (.clk(clk), .rst(rst), .d(prn[0]), .q(prn_s[0]));
   sync2 u_sync1 (.clk(clk), .rst(rst), .d(prn[1]), .q(prn_s[1]));
   sync2 u_sync2 (.clk(clk), .rst(rst), .d(prn[2]), .q(prn_s[2]));

   // A code counts only once it has been stable for two synchronized cycles.
   assign accept    = (prn_s == prn_prev_q) && (prn_s != last_prn_q);
   assign resp_any  = |resp;
   assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
   assign elapsed   = {1'b0, cnt_q} + 25'd1;
   assign hold_done = elapsed >= {9'd0, HOLDOFF_CYCLES};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         prn_prev_q   <= '0;
         last_prn_q   <= '0;
         stim_q       <= '0;
         cnt_q        <= '0;
         res_code_q   <= RES_HIT;
         res_cycles_q <= '0;
      end else begin
         state_q      <= state_d;
         prn_prev_q   <= prn_prev_d;
         last_prn_q   <= last_prn_d;
         stim_q       <= stim_d;
         cnt_q        <= cnt_d;
         res_code_q   <= res_code_d;
         res_cycles_q <= res_cycles_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      prn_prev_d   = prn_s;
      last_prn_d   = last_prn_q;
      stim_d       = stim_q;
      cnt_d        = cnt_q;
      res_code_d   = res_code_q;
      res_cycles_d = res_cycles_q;
      if (!en) begin
         state_d = S_IDLE;
         stim_d  = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_ARMED;
            end
            S_ARMED: begin
               if (accept) begin
                  state_d    = S_STIM;
                  last_prn_d = prn_s;
                  stim_d     = onehot(prn_s);
                  cnt_d      = '0;
               end
            end
            S_STIM: begin
               if (resp_any) begin
                  state_d      = S_REPORT;
                  stim_d       = '0;
                  res_code_d   = (resp == stim_q) ? RES_HIT : RES_WRONG;
                  res_cycles_d = cnt_q;
               end
`ifdef PRN_STIM_TIMEOUT_EN
               else if (cnt_q == TIMEOUT_CYCLES) begin
                  state_d      = S_REPORT;
                  stim_d       = '0;
                  res_code_d   = RES_TIMEOUT;
                  res_cycles_d = TIMEOUT_CYCLES;
               end
`endif
               else begin
                  cnt_d = cnt_inc;
               end
            end
            S_REPORT: begin
               state_d = S_HOLDOFF;
               cnt_d   = '0;
            end
            S_HOLDOFF: begin
               if (hold_done && !resp_any) begin
                  state_d = S_ARMED;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      busy      = (state_q == S_STIM) || (state_q == S_REPORT) ||
                  (state_q == S_HOLDOFF);
      res_valid = (state_q == S_REPORT);
   end

   assign stim       = stim_q;
   assign res_code   = res_code_q;
   assign res_cycles = res_cycles_q;

endmodule

// File: tb/tb_prn_stim_timer.sv
// Self-checking bench for prn_stim_timer with randomized trials.
// Define PRN_STIM_TIMEOUT_EN to check the timeout result path.
module tb_prn_stim_timer;

   localparam int HOLD = 20;
   localparam int TMO  = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  prn;
   logic        en;
   logic [7:0]  resp;
   logic [7:0]  stim;
   logic        busy;
   logic        res_valid;
   logic [1:0]  res_code;
   logic [23:0] res_cycles;

   int errors = 0;
   int checks = 0;
   logic [2:0] exp_last;

   prn_stim_timer #(
      .TIMEOUT_CYCLES(24'd100),
      .HOLDOFF_CYCLES(16'd20)
   ) dut (
      .clk(clk),
      .rst(rst),
      .prn(prn),
      .en(en),
      .resp(resp),
      .stim(stim),
      .busy(busy),
      .res_valid(res_valid),
      .res_code(res_code),
      .res_cycles(res_cycles)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst  = 1'b1;
      en   = 1'b0;
      prn  = 3'd0;
      resp = 8'h00;
      tick(2);
      checks++;
      if (stim !== 8'h00) begin
         errors++;
         $display("FAIL reset_stim got %h want 00", stim);
      end
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got busy=%b valid=%b want 0 0", busy, res_valid);
      end
      checks++;
      if (res_code !== 2'b00 || res_cycles !== 24'd0) begin
         errors++;
         $display("FAIL reset_res got %b/%0d want 00/0", res_code, res_cycles);
      end
      rst = 1'b0;
      en  = 1'b1;
      exp_last = 3'd0;
      tick(1);
   endtask

   task automatic test_ignore;
      int n;
      prn = 3'b001;
      tick(4);
      checks++;
      if (stim !== 8'h02) begin
         errors++;
         $display("FAIL ignore_accept got %h want 02", stim);
      end
      prn = 3'b110;
      tick(8);
      checks++;
      if (stim !== 8'h02 || busy !== 1'b1) begin
         errors++;
         $display("FAIL ignore_hold got %h busy=%b want 02 1", stim, busy);
      end
      resp = 8'h02;
      tick(1);
      resp = 8'h00;
      checks++;
      if (res_valid !== 1'b1 || res_code !== 2'b00) begin
         errors++;
         $display("FAIL ignore_hit got v=%b c=%b want 1 00", res_valid, res_code);
      end
      n = 0;
      while (busy && n < HOLD + 50) begin
         tick(1);
         n++;
      end
      tick(1);
      checks++;
      if (stim !== 8'h40) begin
         errors++;
         $display("FAIL ignore_pending got %h want 40", stim);
      end
      resp = 8'h40;
      tick(1);
      resp = 8'h00;
      n = 0;
      while (busy && n < HOLD + 50) begin
         tick(1);
         n++;
      end
      exp_last = 3'b110;
   endtask

   task automatic test_trials;
      logic [2:0] p;
      logic [7:0] r;
      logic [7:0] oh;
      logic [1:0] ecode;
      int k;
      int n;
      for (int t = 0; t < 10; t++) begin
         if (t == 0) begin
            p = 3'b101; k = 9; r = 8'h20;
         end else if (t == 1) begin
            p = 3'b011; k = 4; r = 8'h0C;
         end else begin
            do p = 3'($urandom_range(0, 7)); while (p == exp_last);
            k = $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 0) r = 8'h01 << p;
            else do r = 8'($urandom_range(1, 255)); while (r == (8'h01 << p));
         end
         oh    = 8'h01 << p;
         ecode = (r == oh) ? 2'b00 : 2'b01;
         prn = p;
         tick(3);
         checks++;
         if (stim !== 8'h00) begin
            errors++;
            $display("FAIL early_stim t=%0d got %h want 00", t, stim);
         end
         tick(1);
         checks++;
         if (stim !== oh || busy !== 1'b1) begin
            errors++;
            $display("FAIL latency t=%0d got %h busy=%b want %h 1", t, stim, busy, oh);
         end
         tick(k);
         resp = r;
         tick(1);
         resp = 8'h00;
         checks++;
         if (res_valid !== 1'b1 || res_code !== ecode) begin
            errors++;
            $display("FAIL result t=%0d got v=%b c=%b want 1 %b", t, res_valid, res_code, ecode);
         end
         checks++;
         if (res_cycles !== 24'(k) || stim !== 8'h00) begin
            errors++;
            $display("FAIL cycles t=%0d got %0d stim=%h want %0d 00", t, res_cycles, stim, k);
         end
         tick(1);
         checks++;
         if (res_valid !== 1'b0 || res_code !== ecode) begin
            errors++;
            $display("FAIL pulse t=%0d got v=%b c=%b want 0 %b", t, res_valid, res_code, ecode);
         end
         n = 0;
         while (busy && n < HOLD + 50) begin
            tick(1);
            n++;
         end
         checks++;
         if (n !== HOLD) begin
            errors++;
            $display("FAIL holdoff t=%0d got %0d want %0d", t, n, HOLD);
         end
         exp_last = p;
      end
   endtask

   task automatic test_glitch;
      logic seen;
      seen = 1'b0;
      prn = exp_last ^ 3'b101;
      tick(1);
      prn = exp_last;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         seen = seen | busy | (|stim);
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL glitch got activity=%b want 0", seen);
      end
   endtask

   task automatic test_timeout;
      logic [2:0] p;
      logic [7:0] oh;
      int n;
      p  = exp_last ^ 3'b010;
      oh = 8'h01 << p;
      prn = p;
      tick(4);
      checks++;
      if (stim !== oh) begin
         errors++;
         $display("FAIL tmo_accept got %h want %h", stim, oh);
      end
`ifdef PRN_STIM_TIMEOUT_EN
      n = 0;
      while (!res_valid && n < 400) begin
         tick(1);
         n++;
      end
      checks++;
      if (res_valid !== 1'b1 || res_code !== 2'b10 || res_cycles !== 24'(TMO)) begin
         errors++;
         $display("FAIL timeout got v=%b c=%b cyc=%0d want 1 10 %0d", res_valid, res_code, res_cycles, TMO);
      end
      checks++;
      if (n !== TMO + 1) begin
         errors++;
         $display("FAIL tmo_time got %0d want %0d", n, TMO + 1);
      end
      n = 0;
      while (busy && n < HOLD + 50) begin
         tick(1);
         n++;
      end
`else
      n = 0;
      for (int i = 0; i < 200; i++) begin
         tick(1);
         if (res_valid) n++;
      end
      checks++;
      if (n !== 0 || stim !== oh) begin
         errors++;
         $display("FAIL no_timeout got valid=%0d stim=%h want 0 %h", n, stim, oh);
      end
      en = 1'b0;
      tick(1);
      checks++;
      if (busy !== 1'b0 || stim !== 8'h00) begin
         errors++;
         $display("FAIL en_stim got busy=%b stim=%h want 0 00", busy, stim);
      end
      en = 1'b1;
      tick(1);
`endif
      exp_last = p;
   endtask

   task automatic test_en_drop;
      logic [2:0] p;
      p = exp_last ^ 3'b100;
      prn = p;
      tick(4);
      resp = 8'h01 << p;
      tick(1);
      resp = 8'h00;
      tick(4);
      en = 1'b0;
      tick(1);
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL en_holdoff got busy=%b valid=%b want 0 0", busy, res_valid);
      end
      en = 1'b1;
      tick(5);
      checks++;
      if (busy !== 1'b0 || stim !== 8'h00) begin
         errors++;
         $display("FAIL en_rearm got busy=%b stim=%h want 0 00", busy, stim);
      end
      exp_last = p;
   endtask

   task automatic test_reset_mid;
      logic [2:0] p;
      p = exp_last ^ 3'b001;
      prn = p;
      tick(6);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (stim !== 8'h00 || busy !== 1'b0 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid got stim=%h busy=%b v=%b want 00 0 0", stim, busy, res_valid);
      end
      checks++;
      if (res_code !== 2'b00 || res_cycles !== 24'd0) begin
         errors++;
         $display("FAIL rst_mid_res got %b/%0d want 00/0", res_code, res_cycles);
      end
      tick(1);
      rst = 1'b0;
      exp_last = 3'd0;
   endtask

   initial begin
      test_reset();
      test_ignore();
      test_trials();
      test_glitch();
      test_timeout();
      test_en_drop();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
